// File: rtl/verb_row_decoder.sv
`timescale 1ns/1ps
// verb_row_decoder
//
// Streams ASCII verb vector rows, one byte per handshake, and hands out one
// decoded binary field per output beat. A row is a line of space-separated
// binary fields terminated by '\n', for example "0101 1 110\n". Carriage
// returns are ignored. Any other byte, or a field or row that does not fit,
// discards the remainder of the row.
//
// Ports
//   clk, rst_n           single rising-edge clock, async active-low reset
//   s_valid/s_ready      input byte handshake, s_data is the ASCII byte
//   m_valid/m_ready      output beat handshake (single-entry register)
//   m_data               field value, right-aligned, zero-extended
//   m_len                number of digits in the field (0 on trailing space)
//   m_index              field position within the row, from 0
//   m_last               this field ends the row
//   err_char             1-cycle pulse, illegal byte seen
//   err_ovf              1-cycle pulse, field or row too long
//   row_abort            1-cycle pulse, current row is being discarded
//   row_count            complete rows emitted, wraps at 2^16
module verb_row_decoder #(
  parameter int FIELD_W    = 32,
  parameter int MAX_FIELDS = 16,
  localparam int LEN_W     = $clog2(FIELD_W + 1),
  localparam int IDX_W     = $clog2(MAX_FIELDS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [7:0]         s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [FIELD_W-1:0] m_data,
  output logic [LEN_W-1:0]   m_len,
  output logic [IDX_W-1:0]   m_index,
  output logic               m_last,
  output logic               err_char,
  output logic               err_ovf,
  output logic               row_abort,
  output logic [15:0]        row_count
);

  typedef enum logic {ST_FIELD, ST_SKIP} state_t;

  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_1  = 8'h31;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_NL = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(FIELD_W);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_FIELDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t             state_q, state_n;
  logic [FIELD_W-1:0] acc_q, acc_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic               ready_en_q;
  logic               mv_q, mv_n;
  logic [FIELD_W-1:0] md_q, md_n;
  logic [LEN_W-1:0]   ml_q, ml_n;
  logic [IDX_W-1:0]   mi_q, mi_n;
  logic               mlast_q, mlast_n;
  logic               err_char_q, err_char_n;
  logic               err_ovf_q, err_ovf_n;
  logic               abort_q, abort_n;
  logic [15:0]        rows_q, rows_n;
  logic               accept;

  // ready_en_q keeps s_ready low throughout reset and for the first edge
  // after release; afterwards a byte is taken whenever the output slot is
  // free or is being emptied this cycle, so an emit never overwrites a beat.
  assign s_ready = ready_en_q & (~mv_q | m_ready);
  assign accept  = s_valid & s_ready;

  assign m_valid   = mv_q;
  assign m_data    = md_q;
  assign m_len     = ml_q;
  assign m_index   = mi_q;
  assign m_last    = mlast_q;
  assign err_char  = err_char_q;
  assign err_ovf   = err_ovf_q;
  assign row_abort = abort_q;
  assign row_count = rows_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FIELD;
      acc_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      ready_en_q <= 1'b0;
      mv_q       <= 1'b0;
      md_q       <= '0;
      ml_q       <= '0;
      mi_q       <= '0;
      mlast_q    <= 1'b0;
      err_char_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      abort_q    <= 1'b0;
      rows_q     <= '0;
    end else begin
      state_q    <= state_n;
      acc_q      <= acc_n;
      len_q      <= len_n;
      idx_q      <= idx_n;
      ready_en_q <= 1'b1;
      mv_q       <= mv_n;
      md_q       <= md_n;
      ml_q       <= ml_n;
      mi_q       <= mi_n;
      mlast_q    <= mlast_n;
      err_char_q <= err_char_n;
      err_ovf_q  <= err_ovf_n;
      abort_q    <= abort_n;
      rows_q     <= rows_n;
    end
  end

  // Byte interpretation. An output beat is loaded only on an accepted
  // delimiter, and acceptance implies the output slot is free this edge.
  always_comb begin
    state_n    = state_q;
    acc_n      = acc_q;
    len_n      = len_q;
    idx_n      = idx_q;
    mv_n       = mv_q & ~m_ready;
    md_n       = md_q;
    ml_n       = ml_q;
    mi_n       = mi_q;
    mlast_n    = mlast_q;
    err_char_n = 1'b0;
    err_ovf_n  = 1'b0;
    abort_n    = 1'b0;
    rows_n     = rows_q;

    if (accept) begin
      case (state_q)
        ST_FIELD: begin
          if (s_data == CH_0 || s_data == CH_1) begin
            if (len_q == LEN_FULL) begin
              err_ovf_n = 1'b1;
              abort_n   = 1'b1;
              state_n   = ST_SKIP;
            end else begin
              acc_n = {acc_q[FIELD_W-2:0], s_data[0]};
              len_n = len_q + LEN_ONE;
            end
          end else if (s_data == CH_SP) begin
            // Empty fields (repeated spaces) are simply collapsed.
            if (len_q != '0) begin
              if (idx_q == IDX_LAST) begin
                err_ovf_n = 1'b1;
                abort_n   = 1'b1;
                state_n   = ST_SKIP;
              end else begin
                mv_n    = 1'b1;
                md_n    = acc_q;
                ml_n    = len_q;
                mi_n    = idx_q;
                mlast_n = 1'b0;
                idx_n   = idx_q + IDX_ONE;
                acc_n   = '0;
                len_n   = '0;
              end
            end
          end else if (s_data == CH_NL) begin
            // A trailing space still owes the row its last beat, so a
            // zero-length beat is sent; a completely blank row sends nothing.
            if (len_q != '0 || idx_q != '0) begin
              mv_n    = 1'b1;
              md_n    = acc_q;
              ml_n    = len_q;
              mi_n    = idx_q;
              mlast_n = 1'b1;
              rows_n  = rows_q + 16'd1;
            end
            idx_n = '0;
            acc_n = '0;
            len_n = '0;
          end else if (s_data != CH_CR) begin
            err_char_n = 1'b1;
            abort_n    = 1'b1;
            state_n    = ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (s_data == CH_NL) begin
            acc_n   = '0;
            len_n   = '0;
            idx_n   = '0;
            state_n = ST_FIELD;
          end
        end
        default: state_n = ST_FIELD;
      endcase
    end
  end

endmodule

// File: tb/tb_verb_row_decoder.sv
`timescale 1ns/1ps
// tb_verb_row_decoder
//
// Drives directed and random ASCII rows into verb_row_decoder and compares
// every beat, pulse count and row count with a string-level row parser.
module tb_verb_row_decoder;

  localparam int FIELD_W    = 32;
  localparam int MAX_FIELDS = 16;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [5:0]  m_len;
  logic [3:0]  m_index;
  logic        m_last;
  logic        err_char;
  logic        err_ovf;
  logic        row_abort;
  logic [15:0] row_count;

  int tests_run;
  int tests_failed;

  int rdy_mode;
  bit ready_live;

  logic [63:0] exp_q[$];
  bit          cur_bits[$];
  bit          model_skip;
  int          field_idx;
  int          rows;
  int          exp_char, exp_ovf, exp_abort;
  int          obs_char, obs_ovf, obs_abort;
  logic [7:0]  row_q[$];

  verb_row_decoder #(.FIELD_W(FIELD_W), .MAX_FIELDS(MAX_FIELDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_len(m_len), .m_index(m_index), .m_last(m_last),
    .err_char(err_char), .err_ovf(err_ovf), .row_abort(row_abort),
    .row_count(row_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference row parser ----------------
  task automatic model_reset();
    exp_q.delete();
    cur_bits.delete();
    model_skip = 0;
    field_idx  = 0;
    rows       = 0;
  endtask

  task automatic model_emit(input bit last);
    longint unsigned v;
    v = 0;
    foreach (cur_bits[i]) v = (v << 1) | longint'(cur_bits[i]);
    exp_q.push_back({21'd0, 32'(v), 6'(cur_bits.size()), 4'(field_idx), last});
    cur_bits.delete();
  endtask

  task automatic model_abort(input bit is_ovf);
    if (is_ovf) exp_ovf++;
    else exp_char++;
    exp_abort++;
    model_skip = 1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (model_skip) begin
      if (b == 8'h0A) begin
        model_skip = 0;
        cur_bits.delete();
        field_idx = 0;
      end
    end else if (b == 8'h30 || b == 8'h31) begin
      if (cur_bits.size() == FIELD_W) model_abort(1'b1);
      else cur_bits.push_back(b[0]);
    end else if (b == 8'h20) begin
      if (cur_bits.size() > 0) begin
        if (field_idx == MAX_FIELDS - 1) model_abort(1'b1);
        else begin
          model_emit(1'b0);
          field_idx++;
        end
      end
    end else if (b == 8'h0A) begin
      if (cur_bits.size() > 0 || field_idx > 0) begin
        model_emit(1'b1);
        rows++;
      end
      field_idx = 0;
    end else if (b != 8'h0D) begin
      model_abort(1'b0);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    int budget;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    #2;
    budget = 0;
    while (!s_ready && budget < 2000) begin
      @(negedge clk);
      #2;
      budget++;
    end
    if (!s_ready) begin
      check_output("s_ready_timeout", 64'd0, 64'd1);
      s_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_byte(b);
      #1;
      s_valid = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_row_q();
    foreach (row_q[i]) begin
      send_byte(row_q[i]);
      if ($urandom_range(0, 4) == 0) @(posedge clk);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || m_valid) && budget < 2000) begin
      @(negedge clk);
      #4;
      budget++;
    end
    if (exp_q.size() != 0 || m_valid) check_output("drain_timeout", 64'd0, 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic push_digits(input int n);
    for (int i = 0; i < n; i++) row_q.push_back($urandom_range(0, 1) ? 8'h31 : 8'h30);
  endtask

  task automatic gen_row();
    int kind, nf;
    logic [7:0] bad;
    row_q.delete();
    kind = $urandom_range(0, 99);
    if (kind < 6) begin
      if ($urandom_range(0, 1)) row_q.push_back(8'h0D);
    end else if (kind < 17) begin
      push_digits($urandom_range(FIELD_W - 1, FIELD_W + 2));
      row_q.push_back(8'h20);
      push_digits(2);
    end else if (kind < 22) begin
      nf = $urandom_range(MAX_FIELDS - 1, MAX_FIELDS + 2);
      for (int i = 0; i < nf; i++) begin
        push_digits($urandom_range(1, 3));
        if (i != nf - 1) row_q.push_back(8'h20);
      end
    end else begin
      if ($urandom_range(0, 4) == 0) row_q.push_back(8'h20);
      nf = $urandom_range(1, 6);
      for (int i = 0; i < nf; i++) begin
        push_digits($urandom_range(0, 3) == 0 ? $urandom_range(9, FIELD_W) : $urandom_range(1, 8));
        if (i != nf - 1) repeat ($urandom_range(1, 2)) row_q.push_back(8'h20);
      end
      if ($urandom_range(0, 4) == 0) row_q.push_back(8'h20);
      if ($urandom_range(0, 4) == 0) row_q.push_back(8'h0D);
      if (kind < 32) begin
        do bad = 8'($urandom_range(33, 126)); while (bad == 8'h30 || bad == 8'h31);
        row_q.insert($urandom_range(0, row_q.size()), bad);
      end
    end
    row_q.push_back(8'h0A);
  endtask

  // ---------------- downstream ready ----------------
  initial begin
    m_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       m_ready = ($urandom_range(0, 99) < 70);
        1:       m_ready = 1'b0;
        default: m_ready = 1'b1;
      endcase
    end
  end

  // ---------------- output monitor ----------------
  // Any held beat must match the oldest expected beat; it is retired when
  // m_ready is high going into the next edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        if (ready_live) check_output("s_ready_rule", 64'(s_ready), 64'(!m_valid || m_ready));
        if (err_char)  obs_char++;
        if (err_ovf)   obs_ovf++;
        if (row_abort) obs_abort++;
        if (m_valid) begin
          if (exp_q.size() == 0) check_output("unexpected_beat", 64'd1, 64'd0);
          else begin
            check_output("beat", {21'd0, m_data, m_len, m_index, m_last}, exp_q[0]);
            if (m_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    string s;
    tests_run = 0; tests_failed = 0;
    exp_char = 0; exp_ovf = 0; exp_abort = 0;
    obs_char = 0; obs_ovf = 0; obs_abort = 0;
    model_reset();
    rdy_mode   = 2;
    ready_live = 0;
    s_valid    = 1'b0;
    s_data     = 8'h00;
    rst_n      = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check_output("reset_outputs", {s_ready, m_valid, m_data, m_len, m_index, m_last,
                                   err_char, err_ovf, row_abort, row_count}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check_output("s_ready_in_release_cycle", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    check_output("s_ready_after_first_edge", 64'(s_ready), 64'd1);
    ready_live = 1;

    // first beat latency and back-pressure
    rdy_mode = 1;
    @(negedge clk);
    apply_stimulus("101 ");
    check_output("beat_latency", 64'(m_valid), 64'd1);
    s_valid = 1'b1;
    s_data  = 8'h31;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      check_output("stall_s_ready", 64'(s_ready), 64'd0);
      check_output("stall_m_data", 64'(m_data), 64'd5);
    end
    s_valid  = 1'b0;
    rdy_mode = 0;
    apply_stimulus("11\n");
    drain();
    check_output("row_count_first_row", 64'(row_count), 64'd1);

    // illegal byte, collapsed spaces, trailing space, blank row
    apply_stimulus("1x1 0\n11\n");
    apply_stimulus("  1  0 \n\n\r\n");
    drain();
    check_output("row_count_directed", 64'(row_count), 64'(16'(rows)));

    // field width boundary: exactly full then one digit too many
    rdy_mode = 2;
    s = "";
    for (int i = 0; i < FIELD_W; i++) s = {s, "1"};
    apply_stimulus({s, "\n", s, "1 0\n0 1\n"});
    // row width boundary: exactly full then one field too many
    s = "";
    for (int i = 0; i < MAX_FIELDS - 1; i++) s = {s, "1 "};
    apply_stimulus({s, "0\n", s, "0 1\n"});
    drain();

    // random rows with random back-pressure
    rdy_mode = 0;
    for (int r = 0; r < 150; r++) begin
      gen_row();
      send_row_q();
      if (r == 75) rdy_mode = 2;
    end
    rdy_mode = 0;
    drain();
    check_output("row_count_random", 64'(row_count), 64'(16'(rows)));

    // reset in the middle of a row
    apply_stimulus("10");
    repeat (2) @(negedge clk);
    ready_live = 0;
    rst_n = 1'b0;
    model_reset();
    #2;
    check_output("mid_row_reset_outputs", {s_ready, m_valid, m_data, m_len, m_index, m_last,
                                           err_char, err_ovf, row_abort, row_count}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ready_live = 1;
    apply_stimulus("1\n");
    drain();
    check_output("row_count_after_reset", 64'(row_count), 64'd1);

    check_output("err_char_pulses", 64'(obs_char), 64'(exp_char));
    check_output("err_ovf_pulses", 64'(obs_ovf), 64'(exp_ovf));
    check_output("row_abort_pulses", 64'(obs_abort), 64'(exp_abort));
    check_output("beats_outstanding", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
